// File: rtl/seg_scan_decoder_pkg.sv
// Shared seven-segment display definitions for the parking meter readback path.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package seg_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_INVALID = 4'hE;

    // Bit positions within the anode vector {a1, a2, a3, a4}.
    localparam int unsigned AN_A1 = 3;
    localparam int unsigned AN_A2 = 2;
    localparam int unsigned AN_A3 = 1;
    localparam int unsigned AN_A4 = 0;

    typedef enum logic [1:0] {
        AnIdle,
        AnValid,
        AnCollision
    } an_class_e;

    function automatic an_class_e an_classify(input logic [3:0] an);
        int unsigned n_low;
        n_low = $countones(~an);
        if (n_low == 0) begin
            return AnIdle;
        end else if (n_low == 1) begin
            return AnValid;
        end
        return AnCollision;
    endfunction

    // Digit slot of the single low anode; slot 0 is a1 (thousands).
    function automatic logic [1:0] an_digit(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        if (!an[AN_A1]) idx = 2'd0;
        if (!an[AN_A2]) idx = 2'd1;
        if (!an[AN_A3]) idx = 2'd2;
        if (!an[AN_A4]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational active-low seven-segment pattern to digit code decoder.
// Unknown patterns map to CODE_INVALID, all-off to CODE_BLANK.
module seg7_to_bcd
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_INVALID;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Observes the multiplexed seven-segment scan and rebuilds coherent 4-digit frames,
// flagging blank frames, lost scanning and anode collisions.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] led_seg,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    input  logic       a4,
    output logic [3:0] val1,
    output logic [3:0] val2,
    output logic [3:0] val3,
    output logic [3:0] val4,
    output logic       frame_stb,
    output logic       blank_frame,
    output logic       scan_lost,
    output logic       collision_err
);

    localparam int unsigned DW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic [3:0]    an_d;
    an_class_e     an_class_d;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [3:0]    mask_q, mask_d;
    logic [3:0]    shadow [4];

    logic          capture;
    logic          publish;
    logic          timeout;
    logic [1:0]    cap_idx;
    logic [6:0]    cap_seg;
    logic [3:0]    cap_code;

    // an_d is the value r_an takes at the coming edge, so dwell and capture
    // decisions line up with the edge that registers the anode pattern.
    assign an_d       = {a1, a2, a3, a4};
    assign an_class_d = an_classify(an_d);
    assign cap_idx    = an_digit(an_d);

    // With a one-cycle settle the capture edge is the registering edge itself.
    assign cap_seg = (SETTLE == 1) ? led_seg : r_seg;

    seg7_to_bcd u_seg7_to_bcd (
        .seg  (cap_seg),
        .code (cap_code)
    );

    always_comb begin
        dwell_d = dwell_q;
        capture = 1'b0;
        if (an_class_d != AnValid) begin
            dwell_d = '0;
        end else if (an_d != r_an) begin
            dwell_d = DW'(1);
            capture = (SETTLE == 1);
        end else if (dwell_q < DW'(SETTLE)) begin
            dwell_d = dwell_q + DW'(1);
            capture = (dwell_d == DW'(SETTLE));
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (capture) begin
            idle_d = '0;
        end else if (idle_q < IW'(TIMEOUT)) begin
            idle_d = idle_q + IW'(1);
        end
        timeout = !capture && (idle_d == IW'(TIMEOUT));
    end

    // A capture coinciding with publish lands in the freshly cleared mask.
    always_comb begin
        publish = (mask_q == 4'b1111);
        mask_d  = publish ? 4'b0000 : mask_q;
        if (timeout) begin
            mask_d = 4'b0000;
        end
        if (capture) begin
            mask_d[cap_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg         <= SEG_BLANK;
            r_an          <= 4'b1111;
            dwell_q       <= '0;
            idle_q        <= '0;
            mask_q        <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= CODE_BLANK;
            end
            val1          <= CODE_BLANK;
            val2          <= CODE_BLANK;
            val3          <= CODE_BLANK;
            val4          <= CODE_BLANK;
            frame_stb     <= 1'b0;
            blank_frame   <= 1'b0;
            scan_lost     <= 1'b0;
            collision_err <= 1'b0;
        end else begin
            r_seg     <= led_seg;
            r_an      <= an_d;
            dwell_q   <= dwell_d;
            idle_q    <= idle_d;
            mask_q    <= mask_d;
            frame_stb <= publish;

            if (capture) begin
                shadow[cap_idx] <= cap_code;
            end

            if (publish) begin
                val1        <= shadow[0];
                val2        <= shadow[1];
                val3        <= shadow[2];
                val4        <= shadow[3];
                blank_frame <= (shadow[0] == CODE_BLANK) && (shadow[1] == CODE_BLANK) &&
                               (shadow[2] == CODE_BLANK) && (shadow[3] == CODE_BLANK);
            end

            if (capture) begin
                scan_lost <= 1'b0;
            end else if (timeout) begin
                scan_lost <= 1'b1;
            end

            if (an_class_d == AnCollision) begin
                collision_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus pushes expected frames from a
// digit-level model, a monitor pops and compares on every frame_stb.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE  = 2;
    localparam int unsigned TIMEOUT = 1024;

    logic       clk;
    logic       rst;
    logic [6:0] led_seg;
    logic       a1, a2, a3, a4;
    logic [3:0] val1, val2, val3, val4;
    logic       frame_stb, blank_frame, scan_lost, collision_err;

    int checks = 0;
    int errors = 0;

    // Expected frame: {val1, val2, val3, val4, blank_frame}.
    logic [16:0] exp_q [$];
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_mask;
    logic [15:0] m_last;
    int          last_idx;

    // Lit segments (active-high, gfedcba) of each decimal digit.
    logic [6:0] seg_on [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg_scan_decoder #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .led_seg       (led_seg),
        .a1            (a1),
        .a2            (a2),
        .a3            (a3),
        .a4            (a4),
        .val1          (val1),
        .val2          (val2),
        .val3          (val3),
        .val4          (val4),
        .frame_stb     (frame_stb),
        .blank_frame   (blank_frame),
        .scan_lost     (scan_lost),
        .collision_err (collision_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] pat_of(input int d);
        logic [6:0] p;
        p = ~seg_on[d];
        return p;
    endfunction

    function automatic logic [3:0] ref_code(input logic [6:0] p);
        for (int d = 0; d < 10; d++) begin
            if (p == pat_of(d)) return 4'(d);
        end
        if (p == 7'h7F) return 4'hF;
        return 4'hE;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'hF;
        m_mask = 4'b0000;
        m_last = 16'hFFFF;
    endtask

    // idx 0..3 = digit slot, 4 = all anodes off, 5 = a1+a3 collision.
    task automatic model_dwell(input int idx, input logic [6:0] pat, input int len);
        if (idx < 4 && len >= int'(SETTLE)) begin
            m_shadow[idx] = ref_code(pat);
            m_mask[idx]   = 1'b1;
            if (m_mask == 4'b1111) begin
                m_last = {m_shadow[0], m_shadow[1], m_shadow[2], m_shadow[3]};
                exp_q.push_back({m_last, m_last == 16'hFFFF});
                m_mask = 4'b0000;
            end
        end
    endtask

    task automatic drive(input int idx, input logic [6:0] pat);
        logic [3:0] an;
        an = 4'b1111;
        if (idx < 4) an[3-idx] = 1'b0;
        else if (idx == 5) an = 4'b0101;
        {a1, a2, a3, a4} = an;
        led_seg = pat;
        last_idx = idx;
    endtask

    // Called at a negedge; holds the pattern across len rising edges.
    task automatic dwell(input int idx, input logic [6:0] pat, input int len);
        model_dwell(idx, pat, len);
        drive(idx, pat);
        repeat (len) @(negedge clk);
    endtask

    task automatic scan_digits(input int d1, input int d2, input int d3, input int d4);
        dwell(0, pat_of(d1), 3);
        dwell(1, pat_of(d2), 3);
        dwell(2, pat_of(d3), 3);
        dwell(3, pat_of(d4), 3);
    endtask

    // Monitor: compares every published frame against the scoreboard head.
    initial begin
        logic        prev_stb;
        logic [16:0] e;
        prev_stb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (frame_stb) begin
                chk("stb_back_to_back", {31'd0, prev_stb}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %0h, expected no frame",
                             {val1, val2, val3, val4, blank_frame});
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", {15'd0, val1, val2, val3, val4, blank_frame}, {15'd0, e});
                end
            end
            prev_stb = frame_stb;
        end
    end

    initial begin
        int idx;
        int len;
        int n;
        int r;
        logic [6:0] pat;

        rst = 1'b1;
        led_seg = 7'h7F;
        {a1, a2, a3, a4} = 4'b1111;
        last_idx = 4;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_vals", {16'd0, val1, val2, val3, val4}, 32'hFFFF);
        chk("rst_flags", {28'd0, frame_stb, blank_frame, scan_lost, collision_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // "0180" with exact publish timing on the last digit.
        dwell(0, pat_of(0), 3);
        dwell(1, pat_of(1), 3);
        dwell(2, pat_of(8), 3);
        model_dwell(3, pat_of(0), 3);
        drive(3, pat_of(0));
        @(posedge clk);
        @(posedge clk);
        #1 chk("stb_before_settle_plus_1", {31'd0, frame_stb}, 32'd0);
        @(posedge clk);
        #1 chk("stb_at_settle_plus_1", {31'd0, frame_stb}, 32'd1);
        chk("vals_0180", {16'd0, val1, val2, val3, val4}, 32'h0180);
        @(negedge clk);
        dwell(4, 7'h7F, 2);

        // All-blank frame, then lit "0179".
        for (int i = 0; i < 4; i++) dwell(i, 7'h7F, 3);
        dwell(4, 7'h7F, 2);
        chk("blank_frame_set", {31'd0, blank_frame}, 32'd1);
        scan_digits(0, 1, 7, 9);
        dwell(4, 7'h7F, 2);
        chk("blank_frame_clear", {31'd0, blank_frame}, 32'd0);

        // One-cycle glitch on a2 after its digit settled.
        dwell(0, pat_of(3), 3);
        dwell(1, pat_of(1), 3);
        dwell(2, pat_of(2), 3);
        dwell(1, pat_of(5), 1);
        dwell(3, pat_of(4), 3);
        dwell(4, 7'h7F, 2);

        // Decoder corner patterns: all-on is 8, lone segment a is invalid.
        dwell(0, 7'h00, 3);
        dwell(1, 7'h7E, 3);
        dwell(2, pat_of(4), 3);
        dwell(3, 7'h7F, 3);
        dwell(4, 7'h7F, 2);

        // Collision mid-frame: flagged, sticky, no capture.
        chk("collision_clear_before", {31'd0, collision_err}, 32'd0);
        dwell(0, pat_of(6), 3);
        dwell(1, pat_of(2), 3);
        dwell(5, pat_of(5), 3);
        chk("collision_set", {31'd0, collision_err}, 32'd1);
        dwell(2, pat_of(9), 3);
        dwell(3, pat_of(3), 3);
        dwell(4, 7'h7F, 2);
        chk("collision_sticky", {31'd0, collision_err}, 32'd1);
        rst = 1'b1;
        #1 chk("collision_rst", {31'd0, collision_err}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Lit frame, then reset after three captures of the next one.
        scan_digits(5, 4, 3, 2);
        dwell(0, pat_of(1), 3);
        dwell(1, pat_of(1), 3);
        dwell(2, pat_of(1), 3);
        rst = 1'b1;
        #1 chk("midframe_rst_vals", {16'd0, val1, val2, val3, val4}, 32'hFFFF);
        chk("midframe_rst_stb", {31'd0, frame_stb}, 32'd0);
        model_reset();
        drive(4, 7'h7F);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dwell(3, pat_of(7), 3);
        scan_digits(2, 4, 6, 8);
        dwell(4, 7'h7F, 2);

        // Timeout: partial frame is dropped, vals hold, next capture recovers.
        scan_digits(1, 2, 3, 4);
        dwell(0, pat_of(9), 3);
        dwell(1, pat_of(9), 3);
        dwell(4, 7'h7F, 1000);
        chk("scan_lost_not_yet", {31'd0, scan_lost}, 32'd0);
        dwell(4, 7'h7F, 40);
        chk("scan_lost_set", {31'd0, scan_lost}, 32'd1);
        chk("timeout_vals_hold", {16'd0, val1, val2, val3, val4}, {16'd0, m_last});
        m_mask = 4'b0000;
        dwell(2, pat_of(5), 3);
        chk("scan_lost_recover", {31'd0, scan_lost}, 32'd0);
        dwell(3, pat_of(6), 3);
        dwell(0, pat_of(7), 3);
        dwell(1, pat_of(8), 3);
        dwell(4, 7'h7F, 2);

        // Randomised scans: random order, dwell length and pattern.
        for (int f = 0; f < 30; f++) begin
            n = int'($urandom_range(4, 9));
            for (int k = 0; k < n; k++) begin
                idx = int'($urandom_range(0, 4));
                while (idx == last_idx) idx = int'($urandom_range(0, 4));
                len = int'($urandom_range(1, 4));
                r = int'($urandom_range(0, 9));
                if (r == 0) pat = 7'h7F;
                else if (r == 1) pat = 7'($urandom);
                else pat = pat_of(int'($urandom_range(0, 9)));
                dwell(idx, pat, len);
            end
        end
        dwell((last_idx == 4) ? 0 : 4, 7'h7F, 4);
        dwell(4, 7'h7F, 4);

        chk("pending_frames", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
